// File: rtl/gpio_bank_ctrl.sv
// Memory-mapped GPIO bank: debounced inputs, output register with set/clear/toggle
// aliases, and per-channel edge flags that drive a single interrupt line.
module gpio_bank_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [31:0] BASE       = 32'h0000_0100,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic [WIDTH-1:0] pins_out,
  output logic             irq
);

  localparam logic [32:0]      LP_LO       = {1'b0, BASE};
  localparam logic [32:0]      LP_HI       = {1'b0, BASE} + 33'd32;
  localparam logic [CNT_W-1:0] LP_DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [3:0] A_IN      = 4'd0;
  localparam logic [3:0] A_OUT     = 4'd1;
  localparam logic [3:0] A_SET     = 4'd2;
  localparam logic [3:0] A_CLR     = 4'd3;
  localparam logic [3:0] A_TGL     = 4'd4;
  localparam logic [3:0] A_RISE_EN = 4'd5;
  localparam logic [3:0] A_FALL_EN = 4'd6;
  localparam logic [3:0] A_FLAGS   = 4'd7;
  localparam logic [3:0] A_IRQ_EN  = 4'd8;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_irq_en;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [31:0]      w_off;
  logic [3:0]       w_idx;
  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic             w_unused_bits;

  logic [WIDTH-1:0] w_differs;
  logic [WIDTH-1:0] w_settle;
  logic [WIDTH-1:0] w_in_next;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [CNT_W-1:0] w_cnt_next [WIDTH];

  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_rise_en_next;
  logic [WIDTH-1:0] w_fall_en_next;
  logic [WIDTH-1:0] w_irq_en_next;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_flags_next;

  // 33-bit compare so a window near the top of the address space cannot wrap
  assign hit   = (addr[1:0] == 2'b00) && ({1'b0, addr} >= LP_LO) && ({1'b0, addr} <= LP_HI);
  assign w_off = addr - BASE;
  assign w_idx = w_off[5:2];
  assign w_wr  = we & hit;
  assign w_wd  = wdata[WIDTH-1:0];
  assign w_unused_bits = ^{wdata, w_off[31:6], w_off[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      assign w_differs[gi]  = r_s2[gi] ^ r_in[gi];
      // Settle on the edge that completes DEB_CYCLES consecutive differing samples
      assign w_settle[gi]   = w_differs[gi] && (r_cnt[gi] == LP_DEB_LAST);
      assign w_in_next[gi]  = w_settle[gi] ? r_s2[gi] : r_in[gi];
      assign w_cnt_next[gi] = (w_differs[gi] && !w_settle[gi]) ? (r_cnt[gi] + CNT_W'(1)) : '0;
      assign w_rise[gi]     = w_settle[gi] &  r_s2[gi] & r_rise_en[gi];
      assign w_fall[gi]     = w_settle[gi] & ~r_s2[gi] & r_fall_en[gi];
    end
  endgenerate

  always_comb begin
    w_out_next     = r_out;
    w_rise_en_next = r_rise_en;
    w_fall_en_next = r_fall_en;
    w_irq_en_next  = r_irq_en;
    w_w1c          = '0;
    if (w_wr) begin
      case (w_idx)
        A_OUT:     w_out_next     = w_wd;
        A_SET:     w_out_next     = r_out | w_wd;
        A_CLR:     w_out_next     = r_out & ~w_wd;
        A_TGL:     w_out_next     = r_out ^ w_wd;
        A_RISE_EN: w_rise_en_next = w_wd;
        A_FALL_EN: w_fall_en_next = w_wd;
        A_FLAGS:   w_w1c          = w_wd;
        A_IRQ_EN:  w_irq_en_next  = w_wd;
        default:   ;
      endcase
    end
    // A new edge outranks a simultaneous clear of the same bit
    w_flags_next = (r_flags & ~w_w1c) | w_rise | w_fall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_in      <= '0;
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_flags   <= '0;
      r_irq_en  <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1      <= pins_in;
      r_s2      <= r_s1;
      r_in      <= w_in_next;
      r_out     <= w_out_next;
      r_rise_en <= w_rise_en_next;
      r_fall_en <= w_fall_en_next;
      r_flags   <= w_flags_next;
      r_irq_en  <= w_irq_en_next;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (w_idx)
        A_IN:      rdata[WIDTH-1:0] = r_in;
        A_OUT:     rdata[WIDTH-1:0] = r_out;
        A_RISE_EN: rdata[WIDTH-1:0] = r_rise_en;
        A_FALL_EN: rdata[WIDTH-1:0] = r_fall_en;
        A_FLAGS:   rdata[WIDTH-1:0] = r_flags;
        A_IRQ_EN:  rdata[WIDTH-1:0] = r_irq_en;
        default:   rdata = '0;
      endcase
    end
  end

  assign pins_out = r_out;
  assign irq      = |(r_flags & r_irq_en);

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl (WIDTH=8, DEB_CYCLES=4, BASE=0x100).
module tb_gpio_bank_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic [7:0]  pins_in;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  pins_out;
  logic        irq;

  int checks;
  int failures;

  gpio_bank_ctrl #(
    .WIDTH(8), .BASE(BASE), .DEB_CYCLES(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .pins_in(pins_in), .addr(addr), .wdata(wdata),
    .we(we), .rdata(rdata), .hit(hit), .pins_out(pins_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    wdata = 32'h0;
    $display("wr addr=%08h data=%08h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = rdata;
    $display("rd addr=%08h data=%08h hit=%0b", a, d, hit);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (pins_out !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs pins_out=%02h irq=%0b required 00/0", pins_out, irq);
    end
    reset = 1'b1;
    cycles(2);
    wr(BASE + 4, 32'hFF);
    checks++;
    if (pins_out !== 8'hFF) begin
      failures++;
      $display("FAIL out_before_reset got=%02h required FF", pins_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (pins_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset pins_out got=%02h required 00", pins_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycles(1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2 || k == 3 || k == 4) continue;
      rd(BASE + 32'(4 * k), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_readback off=%0d got=%08h required 00000000", 4 * k, d);
      end
    end
  endtask

  task automatic test_aliases();
    logic [31:0] d;
    wr(BASE + 4, 32'h0F);
    wr(BASE + 8, 32'h30);
    checks++;
    if (pins_out !== 8'h3F) begin
      failures++;
      $display("FAIL alias_set got=%02h required 3F", pins_out);
    end
    wr(BASE + 12, 32'h05);
    checks++;
    if (pins_out !== 8'h3A) begin
      failures++;
      $display("FAIL alias_clr got=%02h required 3A", pins_out);
    end
    wr(BASE + 16, 32'hFF);
    checks++;
    if (pins_out !== 8'hC5) begin
      failures++;
      $display("FAIL alias_tgl got=%02h required C5", pins_out);
    end
    rd(BASE + 8, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL read_set_alias got=%08h required 00000000", d);
    end
    rd(BASE + 4, d);
    checks++;
    if (d !== 32'hC5) begin
      failures++;
      $display("FAIL read_out got=%08h required 000000C5", d);
    end
    wr(BASE + 0, 32'hFF);
    rd(BASE + 0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL in_read_only got=%08h required 00000000", d);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    pins_in[0] = 1'b1;
    cycles(1);
    cycles(4);
    rd(BASE, d);
    checks++;
    if (d[0] !== 1'b0) begin
      failures++;
      $display("FAIL debounce_early in0=%0b required 0", d[0]);
    end
    cycles(1);
    rd(BASE, d);
    checks++;
    if (d[0] !== 1'b1) begin
      failures++;
      $display("FAIL debounce_settle in0=%0b required 1", d[0]);
    end
    wr(BASE + 20, 32'h02);
    pins_in[1] = 1'b1;
    cycles(3);
    pins_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycles(1);
      rd(BASE, d);
      checks++;
      if (d[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch_in1 cycle=%0d in1=%0b required 0", k, d[1]);
      end
    end
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_flags got=%08h required 00000000", d);
    end
    wr(BASE + 20, 32'h00);
  endtask

  task automatic test_edge_flags();
    logic [31:0] d;
    pins_in[0] = 1'b0;
    pins_in[1] = 1'b1;
    cycles(8);
    wr(BASE + 20, 32'h01);
    wr(BASE + 24, 32'h02);
    wr(BASE + 32, 32'h03);
    rd(BASE, d);
    checks++;
    if (d !== 32'h02 || irq !== 1'b0) begin
      failures++;
      $display("FAIL edge_setup in=%08h irq=%0b required 00000002/0", d, irq);
    end
    pins_in[0] = 1'b1;
    cycles(5);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_early got=%0b required 0", irq);
    end
    cycles(1);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h01 || irq !== 1'b1) begin
      failures++;
      $display("FAIL rise_flag flags=%08h irq=%0b required 00000001/1", d, irq);
    end
    pins_in[1] = 1'b0;
    cycles(8);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h03) begin
      failures++;
      $display("FAIL fall_flag flags=%08h required 00000003", d);
    end
    wr(BASE + 28, 32'h01);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h02 || irq !== 1'b1) begin
      failures++;
      $display("FAIL w1c_ch0 flags=%08h irq=%0b required 00000002/1", d, irq);
    end
    wr(BASE + 28, 32'h02);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_ch1 flags=%08h irq=%0b required 00000000/0", d, irq);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    pins_in[0] = 1'b0;
    cycles(8);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h00) begin
      failures++;
      $display("FAIL collision_pre flags=%08h required 00000000", d);
    end
    pins_in[0] = 1'b1;
    cycles(1);
    cycles(4);
    wr(BASE + 28, 32'h01);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h01 || irq !== 1'b1) begin
      failures++;
      $display("FAIL collision_set_wins flags=%08h irq=%0b required 00000001/1", d, irq);
    end
    wr(BASE + 28, 32'h01);
    rd(BASE + 28, d);
    checks++;
    if (d !== 32'h00) begin
      failures++;
      $display("FAIL collision_clear flags=%08h required 00000000", d);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    wr(BASE + 2, 32'hFF);
    wr(BASE + 6, 32'h00);
    wr(BASE + 36, 32'h00);
    wr(BASE + 32'h44, 32'h00);
    wr(BASE - 4, 32'h00);
    checks++;
    if (pins_out !== 8'hC5) begin
      failures++;
      $display("FAIL decode_no_write pins_out=%02h required C5", pins_out);
    end
    rd(BASE + 2, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL decode_misaligned hit=%0b rdata=%08h required 0/00000000", hit, d);
    end
    rd(BASE + 36, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL decode_above hit=%0b rdata=%08h required 0/00000000", hit, d);
    end
    rd(BASE - 4, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL decode_below hit=%0b rdata=%08h required 0/00000000", hit, d);
    end
    rd(BASE + 32, d);
    checks++;
    if (hit !== 1'b1 || d !== 32'h03) begin
      failures++;
      $display("FAIL decode_top hit=%0b rdata=%08h required 1/00000003", hit, d);
    end
    rd(BASE + 24, d);
    checks++;
    if (d !== 32'h02) begin
      failures++;
      $display("FAIL decode_fall_en_kept got=%08h required 00000002", d);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    pins_in  = 8'h00;
    addr     = 32'h0;
    wdata    = 32'h0;
    we       = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_aliases();
    test_debounce();
    test_edge_flags();
    test_collision();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
